// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues req/gnt/rvalid fetches, buffers
// returned words in order and presents {valid, instruction, pc_address} to decode.
module fetch_stage #(
    parameter int unsigned                DataWidth   = 32,
    parameter logic [DataWidth-1:0]       ResetVector = 32'h0000_0000,
    parameter int unsigned                FifoDepth   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [DataWidth-1:0] redirect_pc,
    input  logic                 stall,
    output logic                 valid,
    output logic [DataWidth-1:0] instruction,
    output logic [DataWidth-1:0] pc_address
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [0:0] StBoot  = 1'b0;
    localparam logic [0:0] StFetch = 1'b1;

    localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);

    logic [0:0]           state_q, state_d;
    logic [DataWidth-1:0] pc_q, pc_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        disc_q, disc_d;
    logic [AW-1:0]        tag_wr_q, tag_wr_d;
    logic [AW-1:0]        tag_rd_q, tag_rd_d;
    logic [AW-1:0]        buf_wr_q, buf_wr_d;
    logic [AW-1:0]        buf_rd_q, buf_rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [DataWidth-1:0] pc_out_q, pc_out_d;

    logic [DataWidth-1:0] tag_mem_q  [FifoDepth];
    logic [DataWidth-1:0] buf_pc_q   [FifoDepth];
    logic [DataWidth-1:0] buf_word_q [FifoDepth];

    logic          grant;
    logic          push;
    logic          pop;
    logic [SW-1:0] credit_used;
    logic [CW-1:0] remain;

    always_comb begin
        state_d     = StFetch;
        credit_used = {1'b0, outst_q} + {1'b0, count_q};
        imem_req    = (state_q == StFetch) && (credit_used < SW'(FifoDepth));
        grant       = imem_req && imem_gnt;
        push        = imem_rvalid && (disc_q == '0) && !redirect;
        pop         = (count_q != '0) && !stall && !redirect;

        outst_d  = outst_q + CW'(grant) - CW'(imem_rvalid);
        tag_wr_d = tag_wr_q + AW'(grant);
        tag_rd_d = tag_rd_q + AW'(imem_rvalid);

        // Every request still in flight after this edge is stale once redirected.
        if (redirect) begin
            disc_d = outst_d;
        end else if (imem_rvalid && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end else begin
            disc_d = disc_q;
        end

        if (redirect) begin
            pc_d = redirect_pc & ~DataWidth'(3);
        end else if (grant) begin
            pc_d = pc_q + DataWidth'(4);
        end else begin
            pc_d = pc_q;
        end

        remain   = count_q - CW'(pop);
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        if (redirect) begin
            buf_wr_d = '0;
            buf_rd_d = '0;
            count_d  = '0;
        end else begin
            buf_wr_d = buf_wr_q + AW'(push);
            buf_rd_d = buf_rd_q + AW'(pop);
            count_d  = remain + CW'(push);
            // Output regs track the next head; an empty-before-push head is the new word.
            if (remain == '0) begin
                if (push) begin
                    instr_d  = imem_rdata;
                    pc_out_d = tag_mem_q[tag_rd_q];
                end
            end else begin
                instr_d  = buf_word_q[buf_rd_d];
                pc_out_d = buf_pc_q[buf_rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StBoot;
            pc_q     <= ResetVector;
            outst_q  <= '0;
            disc_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
            count_q  <= '0;
            instr_q  <= Nop;
            pc_out_q <= ResetVector;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            buf_wr_q <= buf_wr_d;
            buf_rd_q <= buf_rd_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (push) begin
            buf_word_q[buf_wr_q] <= imem_rdata;
            buf_pc_q[buf_wr_q]   <= tag_mem_q[tag_rd_q];
        end
    end

    assign imem_addr   = pc_q;
    assign valid       = (count_q != '0);
    assign instruction = instr_q;
    assign pc_address  = pc_out_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the RV32I pipeline, sitting directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small in-order queue, so decode backpressure does not stall the memory port. It presents {valid, instruction, pc_address} to decode and handles control-flow redirects from branch, jal and jalr resolution by flushing and discarding stale fetches.

Parameters:
DataWidth, 32, width of PC, addresses and instruction words
ResetVector, 32'h0000_0000, PC value loaded on reset
FifoDepth, 2, instruction buffer entries; also the maximum number of outstanding plus buffered fetches (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  DataWidth  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid; responses return in order, at least 1 cycle after gnt
imem_rdata  input  DataWidth  response instruction word
redirect  input  1  control-flow change; fetch restarts at redirect_pc
redirect_pc  input  DataWidth  redirect target; bits [1:0] are ignored and forced to 0
stall  input  1  decode cannot accept the current instruction
valid  output  1  instruction/pc_address hold a live instruction for decode
instruction  output  DataWidth  instruction word at the buffer head
pc_address  output  DataWidth  PC of that instruction

Behaviour:
- Reset (rst=0, asynchronous) forces the following values: pc=ResetVector, FSM=BOOT, buffer empty, outstanding=0, discard=0. Outputs: imem_req=0, imem_addr=ResetVector, valid=0, instruction=32'h0000_0013 (NOP), pc_address=ResetVector.
- FSM has two states:
  - BOOT: lasts one cycle after reset release with req=0, then moves to FETCH.
  - FETCH: steady state. Asserting rst from either state returns the FSM to BOOT.
- Credit rule: imem_req=1 in FETCH only when (outstanding + occupancy) < FifoDepth. This guarantees that every returning word has a free buffer slot, so the buffer never overflows.
- Handshake rules:
  - imem_addr=pc. While req=1 and gnt=0, req and addr are held stable; req is not withdrawn, except by redirect.
  - A grant occurs when req && gnt. On a grant: pc <= pc+4 and outstanding increments. pc wraps from 32'hFFFF_FFFC to 0.
- Each fetched PC travels with its request through a PC tag queue of depth FifoDepth, so the response is pushed into the buffer as a {pc, word} pair.
- Response handling (imem_rvalid=1):
  - If discard>0, the word is dropped and discard decrements.
  - Otherwise the {pc, word} pair is pushed into the buffer.
  - In both cases outstanding decrements.
- Output: valid = buffer not empty; instruction and pc_address show the head entry, registered-from-buffer (no combinational path from imem_rdata). Latency from gnt to valid is at least 2 cycles (rvalid cycle + 1).
- Pop: the head is removed when valid && !stall. Push and pop in the same cycle are allowed, including when the buffer is full, because the slot was reserved by credit.
- Empty buffer: valid=0; instruction and pc_address hold their last values.
- Redirect (highest priority), applied on the rising edge where redirect=1:
  - buffer flushed, so valid=0 the next cycle;
  - pc <= {redirect_pc[31:2], 2'b00};
  - discard <= outstanding, including any request granted in this same cycle and excluding any response arriving in this same cycle that was itself discarded or would have been pushed (that response is dropped).
  - In the redirect cycle, req remains as computed, but a grant in that cycle is to the old pc and is counted into discard.
  - From the next cycle, fetching proceeds from the new pc. New requests may issue while discard>0, since in-order return makes them distinguishable by count.
- Simultaneous cases:
  - redirect and stall: redirect wins.
  - redirect and pop: the pop is irrelevant because the buffer is flushed.
  - Back-to-back redirects: the last one wins, and discard accumulates the outstanding count.
- Counters outstanding and discard are $clog2(FifoDepth)+1 bits and never exceed FifoDepth.

Test Plan:
- Reset release, memory with gnt=1 and 1-cycle rvalid, stall=0 -> BOOT 1 cycle; req addresses 0,4,8,...; valid first at cycle 3 with pc_address=0; then one instruction per cycle in order.
- stall=1 held for 5 cycles with FifoDepth=2 -> at most 2 buffered plus 0 outstanding; req drops; valid, instruction and pc_address stable; on stall release, pc_addresses continue with no gaps or duplicates.
- imem_gnt=0 for 3 cycles -> imem_req=1 and imem_addr constant (e.g. 32'h10) throughout; the grant then advances addr to 32'h14.
- redirect with redirect_pc=32'h0000_0103 while 2 requests are outstanding -> both responses dropped; next request addr=32'h100; first valid has pc_address=32'h100.
- redirect coincident with gnt and rvalid -> the granted fetch and the arriving word are both discarded; no stale instruction ever reaches valid=1.
- rst asserted mid-stream with outstanding=2 -> outputs return to reset values immediately; after release, the late rvalid of the old fetch is not expected, and fetch restarts at ResetVector.
